// File: rtl/serial_rx_param.sv
// serial_rx_param: parametrised async serial receiver with framing/parity checks and valid/ready output (parity enabled by RX_PARITY_EN)
module serial_rx_param #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun,
  output logic              busy
);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_HALF = CW'(HALF - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t            r_state, w_next;
  logic              r_sync1, r_sync2, r_pbad;
  logic [CW-1:0]     r_cnt;
  logic [BW-1:0]     r_bit;
  logic [DATA_W-1:0] r_shift;
  logic              w_tick, w_done, w_good;

  assign w_tick = r_cnt == ((r_state == START) ? C_HALF : C_LAST);
  assign w_done = (r_state == STOP) && w_tick;
  assign w_good = w_done && r_sync2 && !r_pbad;
  assign busy   = r_state != IDLE;

  // two-flop synchroniser on the raw line, idling high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= tx;
      r_sync2 <= r_sync1;
    end
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end

  // next-state: each non-idle state advances on its sample tick
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   w_next = r_sync2 ? IDLE : START;
      START:  if (w_tick) w_next = r_sync2 ? IDLE : DATA;
`ifdef RX_PARITY_EN
      DATA:   if (w_tick && r_bit == B_LAST) w_next = PARITY;
      PARITY: if (w_tick) w_next = STOP;
`else
      DATA:   if (w_tick && r_bit == B_LAST) w_next = STOP;
`endif
      STOP:   if (w_tick) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // cycle/bit counters, LSB-first shift register and latched parity verdict
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_pbad  <= 1'b0;
    end else begin
      r_cnt <= (r_state == IDLE || w_tick) ? '0 : r_cnt + CW'(1);
      r_bit <= (r_state == IDLE) ? '0 : r_bit + BW'(r_state == DATA && w_tick);
      if (r_state == DATA && w_tick) r_shift <= DATA_W'({r_sync2, r_shift} >> 1);
`ifdef RX_PARITY_EN
      if (r_state == PARITY && w_tick) r_pbad <= (^{r_shift, r_sync2}) != PARITY_ODD;
`endif
    end
  end

  // output word, handshake, framing pulse and sticky overrun
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= w_done && !r_sync2;
      if (w_good && (!out_valid || out_ready)) begin
        out_valid <= 1'b1;
        out_data  <= r_shift;
      end else if (out_ready) out_valid <= 1'b0;
      if (w_good && out_valid && !out_ready) overrun <= 1'b1;
    end
  end

`ifdef RX_PARITY_EN
  // parity error pulse on the stop-sample edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) parity_err <= 1'b0;
    else parity_err <= w_done && r_pbad;
  end
`else
  assign parity_err = PARITY_ODD & 1'b0;
`endif
endmodule

// File: tb/tb_serial_rx_param.sv
// tb_serial_rx_param: directed and randomized frames checked against a frame-level model
module tb_serial_rx_param;
  localparam int DW = 8;
  localparam int CPB = 4;
  localparam bit PODD = 1'b0;
`ifdef RX_PARITY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          tx = 1'b1;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_valid, frame_err, parity_err, overrun, busy;

  int checks = 0;
  int errors = 0;
  logic          exp_valid = 1'b0;
  logic          exp_ovr = 1'b0;
  logic [DW-1:0] exp_data = '0;

  always #5 clk = ~clk;

  serial_rx_param #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY_ODD(PODD)) dut (
    .clk(clk), .reset(reset), .tx(tx), .out_ready(out_ready), .out_data(out_data),
    .out_valid(out_valid), .frame_err(frame_err), .parity_err(parity_err),
    .overrun(overrun), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic stop_b, input logic par_ok, input bit cb);
    logic p;
    p = (^d) ^ PODD ^ !par_ok;
    tx = 1'b0;
    for (int c = 1; c <= CPB; c++) begin
      @(negedge clk);
      if (cb && c == 2) chk("busy_before_e0", 32'(busy), 32'd0);
      if (cb && c == 3) chk("busy_at_e0", 32'(busy), 32'd1);
    end
    for (int i = 0; i < DW; i++) begin
      tx = d[i];
      repeat (CPB) @(negedge clk);
    end
    if (PEN) begin
      tx = p;
      repeat (CPB) @(negedge clk);
    end
    tx = stop_b;
    repeat (CPB) @(negedge clk);
    tx = 1'b1;
  endtask

  task automatic frame(input logic [7:0] d, input logic stop_b, input logic par_ok, input logic rdy, input int gap);
    logic good;
    out_ready = rdy;
    if (rdy) exp_valid = 1'b0;
    repeat (gap) @(negedge clk);
    good = stop_b && (par_ok || !PEN);
    send(d, stop_b, par_ok, 1'b0);
    if (good && !exp_valid) begin
      exp_valid = 1'b1;
      exp_data = d;
    end else if (good) exp_ovr = 1'b1;
    @(negedge clk);
    chk("valid", 32'(out_valid), 32'(exp_valid));
    chk("data", 32'(out_data), 32'(exp_data));
    chk("overrun", 32'(overrun), 32'(exp_ovr));
    chk("frame_err", 32'(frame_err), 32'(!stop_b));
    chk("parity_err", 32'(parity_err), 32'(PEN && stop_b && !par_ok));
    if (!good) begin
      @(negedge clk);
      chk("err_pulse_end", 32'({frame_err, parity_err}), 32'd0);
      repeat (6) @(negedge clk);
    end
  endtask

  initial begin
    logic seen;
    logic [7:0] d;
    logic sb, po;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_flags", 32'({frame_err, parity_err, overrun, busy}), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    send(8'hA5, 1'b1, 1'b1, 1'b1);
    chk("busy_at_f", 32'(busy), 32'd1);
    chk("valid_before_f", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("good_valid", 32'(out_valid), 32'd1);
    chk("good_data", 32'(out_data), 32'hA5);
    chk("good_busy_after_f", 32'(busy), 32'd0);
    chk("good_errs", 32'({frame_err, parity_err, overrun}), 32'd0);
    @(negedge clk);
    chk("accept_drop", 32'(out_valid), 32'd0);
    exp_data = 8'hA5;

    tx = 1'b0;
    @(negedge clk);
    tx = 1'b1;
    repeat (4) @(negedge clk);
    chk("false_start_busy", 32'(busy), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid || frame_err || parity_err || busy) seen = 1'b1;
    end
    chk("false_start_quiet", 32'(seen), 32'd0);

    frame(8'h3C, 1'b0, 1'b1, 1'b1, 0);
    frame(8'h81, 1'b1, 1'b1, 1'b1, 0);

    @(negedge clk);
    exp_valid = 1'b0;
    out_ready = 1'b0;
    send(8'h11, 1'b1, 1'b1, 1'b0);
    send(8'h22, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_data_held", 32'(out_data), 32'h11);
    chk("bp_overrun", 32'(overrun), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_drained", 32'(out_valid), 32'd0);
    exp_data = 8'h11;
    exp_ovr = 1'b1;

`ifdef RX_PARITY_EN
    frame(8'h07, 1'b1, 1'b0, 1'b1, 0);
    frame(8'h07, 1'b1, 1'b1, 1'b1, 0);
`endif

    for (int n = 0; n < 30; n++) begin
      d = 8'($urandom);
      sb = $urandom_range(0, 5) != 0;
      po = !sb || ($urandom_range(0, 4) != 0);
      frame(d, sb, po, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end

    out_ready = 1'b1;
    @(negedge clk);
    exp_valid = 1'b0;
    frame(8'h33, 1'b1, 1'b1, 1'b0, 0);
    tx = 1'b0;
    repeat (CPB) @(negedge clk);
    tx = 1'b1;
    repeat (4 * CPB + 2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    chk("mid_rst_flags", 32'({frame_err, parity_err, overrun, busy}), 32'd0);
    exp_valid = 1'b0;
    exp_data = '0;
    exp_ovr = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    frame(8'h5A, 1'b1, 1'b1, 1'b1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
